// File: rtl/ssd_mux_ctrl.sv
// rtl/ssd_mux_ctrl.sv - N-digit multiplexed seven-segment controller with shadow buffer, LZ blanking and PWM
module ssd_mux_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    fast_clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    frame_start
);

    localparam int PHASE_LEN = REFRESH_DIV / 16;
    localparam int PH_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // The slot counter is kept as (phase, cycle-within-phase) so no divider is needed
    logic [PH_W-1:0]         ph_cnt;
    logic [3:0]              phase;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pend_valid;
    logic [3:0]              bri_q;

    logic                    phase_end;
    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_en;
    logic                    cur_supp;
    logic                    lit;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b1001000;
            4'hB:    glyph = 7'b1001110;
            4'hC:    glyph = 7'b1111110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign phase_end = (ph_cnt == PH_W'(PHASE_LEN - 1));
    assign slot_end  = phase_end && (phase == 4'd15);
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    // Prescaler and digit scan; brightness is latched at every slot start
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            ph_cnt <= '0;
            phase  <= '0;
            idx    <= '0;
            bri_q  <= brightness;
        end else if (phase_end) begin
            ph_cnt <= '0;
            phase  <= phase + 4'd1;
            if (slot_end) begin
                idx   <= frame_end ? '0 : idx + IDX_W'(1);
                bri_q <= brightness;
            end
        end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
        end
    end

    // Shadow buffer: active only changes at the frame boundary; a load on that cycle waits a frame
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            pending    <= '0;
            active     <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (frame_end && pend_valid)
                active <= pending;
            if (load) begin
                pending    <= digits_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero mask from the active buffer, scanning down from the top digit; digit 0 never blanks
    always_comb begin
        supp     = '0;
        zero_run = lz_suppress;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (active[4*k +: 4] == 4'd0);
            supp[k]  = zero_run;
        end
    end

    // Select the nibble, enable and suppression bit for the digit being scanned
    always_comb begin
        cur_nib  = 4'hF;
        cur_en   = 1'b0;
        cur_supp = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib  = active[4*k +: 4];
                cur_en   = digit_en[k];
                cur_supp = supp[k];
            end
        end
        lit = cur_en && !cur_supp && (cur_nib < 4'hD) && (phase <= bri_q);
    end

    // Registered pin drive: at most one anode low, everything dark otherwise
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            anode       <= '1;
            seg         <= 7'b1111111;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (idx == '0) && (phase == 4'd0) && (ph_cnt == '0);
            if (lit) begin
                anode <= ~(NUM_DIGITS'(1) << idx);
                seg   <= glyph(cur_nib);
            end else begin
                anode <= '1;
                seg   <= 7'b1111111;
            end
        end
    end

endmodule
